// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, S-box and word helpers.
// Also holds the FSM state encoding used by the controller.
package aes_pkg;

   localparam int KEY_W      = 128;
   localparam int NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Row-major FIPS-197 S-box; byte 0x00 sits in the top 8 bits.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      int sh;
      sh = 8 * (255 - int'(b));
      return SBOX_TBL[sh +: 8];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]),  sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Load/status/read-port bundle between the cipher core and the
// key-schedule controller.
interface aes_key_sched_ctrl_if;
   import aes_pkg::*;

   logic [KEY_W-1:0] key_in;
   logic             start;
   logic             busy;
   logic             done;
   logic             keys_valid;
   logic [3:0]       rk_addr;
   logic             rk_rd;
   logic [KEY_W-1:0] rk_data;
   logic             rk_data_vld;

   modport master (
      output key_in, start, rk_addr, rk_rd,
      input  busy, done, keys_valid, rk_data, rk_data_vld
   );

   modport slave (
      input  key_in, start, rk_addr, rk_rd,
      output busy, done, keys_valid, rk_data, rk_data_vld
   );

endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: 4 S-box lanes plus the XOR chain.
module aes_key_round
   import aes_pkg::*;
(
   input  logic [KEY_W-1:0] prev_key,
   input  logic [7:0]       rcon,
   output logic [KEY_W-1:0] next_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t, n0, n1, n2, n3;

   assign w0 = prev_key[127:96];
   assign w1 = prev_key[95:64];
   assign w2 = prev_key[63:32];
   assign w3 = prev_key[31:0];

   assign t  = sub_word(rot_word(w3)) ^ {rcon, 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller with an 11-entry
// round-key store and a registered read port.
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input logic               clk,
   input logic               rst,
   aes_key_sched_ctrl_if.slave bus
);

   state_t              state_q, state_d;
   logic [3:0]          rnd_q, rnd_d;
   logic [KEY_W-1:0]    prev_q, prev_d;
   logic [NUM_ROUNDS:0] vld_q, vld_d;
   logic                kv_q, kv_d;
   logic                busy_q, done_q;
   logic                rd_vld_q;
   logic [KEY_W-1:0]    rd_q;
   logic [KEY_W-1:0]    next_key;
   logic                we;
   logic [3:0]          wa;
   logic [KEY_W-1:0]    wd;
   logic [KEY_W-1:0]    rf [0:NUM_ROUNDS];

   aes_key_round u_round (
      .prev_key (prev_q),
      .rcon     (rcon_of(rnd_q)),
      .next_key (next_key)
   );

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      prev_d  = prev_q;
      vld_d   = vld_q;
      kv_d    = kv_q;
      we      = 1'b0;
      wa      = rnd_q;
      wd      = next_key;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               we      = 1'b1;
               wa      = 4'd0;
               wd      = bus.key_in;
               vld_d   = {{NUM_ROUNDS{1'b0}}, 1'b1};
               kv_d    = 1'b0;
               prev_d  = bus.key_in;
               rnd_d   = 4'd1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            we           = 1'b1;
            vld_d[rnd_q] = 1'b1;
            prev_d       = next_key;
            if (rnd_q == 4'(NUM_ROUNDS)) begin
               kv_d    = 1'b1;
               state_d = DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         DONE: begin
            rnd_d   = 4'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rnd_q    <= 4'd0;
         prev_q   <= '0;
         vld_q    <= '0;
         kv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_vld_q <= 1'b0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         prev_q   <= prev_d;
         vld_q    <= vld_d;
         kv_q     <= kv_d;
         busy_q   <= (state_d == EXPAND);
         done_q   <= (state_d == DONE);
         rd_vld_q <= bus.rk_rd;
         // Unwritten or out-of-range entries read back as zero.
         if (bus.rk_rd) begin
            if (bus.rk_addr <= 4'(NUM_ROUNDS) && vld_q[bus.rk_addr])
               rd_q <= rf[bus.rk_addr];
            else
               rd_q <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         rf[wa] <= wd;
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.keys_valid  = kv_q;
   assign bus.rk_data     = rd_q;
   assign bus.rk_data_vld = rd_vld_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: known-answer table, random keys
// against a word-level FIPS-197 model, and multi-cycle corner cases.
module tb_aes_key_sched_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   aes_key_sched_ctrl_if bus ();

   aes_key_sched_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   addr;
      logic [127:0] exp;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   sb  [256];
   logic [127:0] mdl [11];

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(logic [7:0] b, int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from the field inverse and affine map, not from a table.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^
                 rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for done, counting edges since the start edge.
   task automatic wait_done(input int c0, input string nm);
      int c;
      c = c0;
      while (c < 20) begin
         tick();
         c++;
         if (bus.done) break;
      end
      chk(nm, 128'(c), 128'd10);
      chk({nm, "_kv"}, 128'(bus.keys_valid), 128'd1);
   endtask

   task automatic run_sched(input logic [127:0] k);
      bus.key_in = k;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      chk("busy_rise", 128'(bus.busy), 128'd1);
      wait_done(0, "done_lat");
   endtask

   task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
      bus.rk_addr = a;
      bus.rk_rd   = 1'b1;
      tick();
      bus.rk_rd   = 1'b0;
      chk("rd_vld", 128'(bus.rk_data_vld), 128'd1);
      d = bus.rk_data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vt [6];
      logic [127:0] d, ka, kb, exp;

      rst         = 1'b1;
      bus.key_in  = '0;
      bus.start   = 1'b0;
      bus.rk_addr = '0;
      bus.rk_rd   = 1'b0;
      build_sbox();

      vt[0] = '{FIPS_K,  4'd1,  FIPS_R1};
      vt[1] = '{FIPS_K,  4'd10, FIPS_R10};
      vt[2] = '{FIPS_K,  4'd0,  FIPS_K};
      vt[3] = '{128'h0,  4'd1,  ZERO_R1};
      vt[4] = '{128'h0,  4'd10, ZERO_R10};
      vt[5] = '{FIPS_K,  4'd12, 128'h0};

      #12;
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_done", 128'(bus.done), 128'd0);
      chk("rst_kv", 128'(bus.keys_valid), 128'd0);
      chk("rst_vld", 128'(bus.rk_data_vld), 128'd0);
      chk("rst_data", bus.rk_data, 128'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_sched(vt[i].key);
         tick();
         read_rk(vt[i].addr, d);
         chk($sformatf("kat%0d", i), d, vt[i].exp);
      end

      for (int n = 0; n < 3; n++) begin
         ka = {$urandom, $urandom, $urandom, $urandom};
         model(ka);
         run_sched(ka);
         tick();
         for (int a = 0; a < 16; a++) begin
            read_rk(4'(a), d);
            exp = (a <= 10) ? mdl[a] : 128'h0;
            chk($sformatf("rnd%0d_a%0d", n, a), d, exp);
         end
         tick();
         chk("vld_idle", 128'(bus.rk_data_vld), 128'd0);
         chk("data_hold", bus.rk_data, 128'h0);
      end

      // Reads racing the expansion.
      model(FIPS_K);
      bus.key_in = FIPS_K;
      bus.start  = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.rk_addr = 4'd1;
      bus.rk_rd   = 1'b1;
      tick();
      chk("same_edge", bus.rk_data, 128'h0);
      bus.rk_addr = 4'd5;
      tick();
      bus.rk_rd = 1'b0;
      chk("exp_rd_data", bus.rk_data, 128'h0);
      chk("exp_rd_vld", 128'(bus.rk_data_vld), 128'd1);
      wait_done(2, "done_lat2");
      tick();
      read_rk(4'd5, d);
      chk("post_a5", d, mdl[5]);

      // start during EXPAND is dropped.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = ~ka;
      model(ka);
      bus.key_in = ka;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      bus.key_in = kb;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(4, "done_lat3");
      tick();
      read_rk(4'd10, d);
      chk("ign_a10", d, mdl[10]);
      read_rk(4'd0, d);
      chk("ign_a0", d, ka);
      chk("ign_busy", 128'(bus.busy), 128'd0);

      // Asynchronous reset in the middle of expansion.
      bus.key_in = FIPS_K;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 128'(bus.busy), 128'd0);
      chk("arst_kv", 128'(bus.keys_valid), 128'd0);
      chk("arst_data", bus.rk_data, 128'h0);
      chk("arst_vld", 128'(bus.rk_data_vld), 128'd0);
      #1 rst = 1'b0;
      tick();
      read_rk(4'd3, d);
      chk("arst_a3", d, 128'h0);
      run_sched(FIPS_K);
      tick();
      read_rk(4'd10, d);
      chk("arst_a10", d, FIPS_R10);

      // Back-to-back schedules.
      run_sched(128'h0);
      tick();
      chk("b2b_kv_hold", 128'(bus.keys_valid), 128'd1);
      bus.key_in = FIPS_K;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("b2b_kv_drop", 128'(bus.keys_valid), 128'd0);
      chk("b2b_busy", 128'(bus.busy), 128'd1);
      wait_done(0, "b2b_lat");
      tick();
      read_rk(4'd10, d);
      chk("b2b_a10", d, FIPS_R10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Iterative AES-128 key-schedule controller. Loads a 128-bit cipher key, then drives one shared single-round expansion datapath for 10 consecutive cycles.
- Stores round keys 0..10 in an internal 11x128 register file.
- Serves stored round keys to the cipher core through a registered read port, so the core never recomputes keys per block.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128, other values unsupported.
- KEY_W, 128, key and round-key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  128  cipher key; w0 = key_in[127:96], w3 = key_in[31:0].
- start  input  1  one-cycle request to expand key_in; sampled only in IDLE.
- busy  output  1  high while EXPAND is active.
- done  output  1  one-cycle pulse when round key 10 has been written.
- keys_valid  output  1  high once a full schedule is stored; cleared by start or rst.
- rk_addr  input  4  round-key index 0..10.
- rk_rd  input  1  read strobe.
- rk_data  output  128  registered round key.
- rk_data_vld  output  1  high the cycle after rk_rd.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; busy, done, keys_valid, rk_data_vld = 0; rk_data = 0.
  - round counter = 0; per-entry valid mask = 0.
  - Register-file contents are don't-care.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - On start=1: write key_in to entry 0, set valid[0]=1, clear valid[10:1], keys_valid=0.
  - Load prev_key = key_in, rnd = 1, go to EXPAND.
- EXPAND, one round per cycle:
  - next = aes_key_round(prev_key, rcon(rnd)); write next to entry rnd; set valid[rnd]; prev_key = next.
  - If rnd == 10 go to DONE; otherwise rnd = rnd + 1.
- DONE (exactly one cycle): done=1, keys_valid=1, then return to IDLE.
- busy = 1 only in EXPAND; it is registered and rises the cycle after start is accepted.
- Latency: start accepted at edge N → entry 10 written at edge N+10 → done high in the cycle following edge N+10 (10 cycles after the start edge).
- start while in EXPAND or DONE: ignored, no queueing.
- Round function, per FIPS-197:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Output {w0', w1', w2', w3'}.
- rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Read port:
  - rk_rd at edge N → rk_data and rk_data_vld=1 valid after edge N.
  - rk_data_vld is 0 in any cycle without a preceding rk_rd.
  - rk_data holds its last value when not reading.
- Read boundary conditions:
  - rk_addr > 10, or entry not yet valid (read during expansion) → rk_data = 0 with rk_data_vld = 1.
  - Read of the entry being written at the same edge returns the old value, i.e. 0 because it is still invalid.
- rst mid-EXPAND: immediate return to IDLE with all valids cleared. The next start restarts cleanly.
- No combinational path from inputs to outputs.

Decomposition:
- Package aes_pkg:
  - KEY_W, NUM_ROUNDS, RCON table as a constant function or array.
  - sbox byte function, SubWord and RotWord functions.
  - FSM state encoding: IDLE=2'd0, EXPAND=2'd1, DONE=2'd2.
- Sub-module aes_key_round: purely combinational single-round expansion (4 S-box lanes + XOR chain). Inputs prev_key[127:0] and rcon[7:0]; output next_key[127:0].
- The controller instantiates exactly one aes_key_round and shares it across all rounds.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - done exactly 10 cycles after the start edge.
  - Read addr 1 → a0fafe1788542cb123a339392a6c7605.
  - Read addr 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Read addr 0 → key_in.
- All-zero key:
  - Addr 1 → 62636363626363636263636362636363.
  - Addr 10 → b4ef5bcb3e92e21123e951cf6f8f188e.
  - keys_valid=1 after done.
- Reads during expansion and out of range:
  - rk_rd addr 5 during EXPAND cycle 2 → rk_data=0, vld=1.
  - addr 11..15 after done → 0.
- start re-asserted during EXPAND with a different key:
  - Ignored; the original schedule completes.
  - Addr 10 still matches the first key.
- rst asserted mid-EXPAND at cycle 4:
  - Outputs go to 0 asynchronously; keys_valid=0; reading addr 3 → 0.
  - A new start with the FIPS key yields the correct addr 10.
- Back-to-back start:
  - start in the cycle after done is accepted.
  - keys_valid drops to 0, then returns to 1 after 10 more cycles.
